// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and helpers for the hazard/stall control block.
package hazard_stall_unit_pkg;

    localparam int NB_HZ_STATE = 2;

    typedef enum logic [NB_HZ_STATE-1:0] {
        HZ_STATE_RUN    = 2'd0,
        HZ_STATE_STALL  = 2'd1,
        HZ_STATE_DRAIN  = 2'd2,
        HZ_STATE_HALTED = 2'd3
    } hz_state_e;

    // Bits needed to hold any value in 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Enabled up-counter that sticks at all-ones instead of wrapping.
module hazard_sat_counter
    import hazard_stall_unit_pkg::*;
#(
    parameter int NB = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          inc,
    output logic [NB-1:0] count
);

    // Count enabled events, synchronous reset, saturate at all-ones.
    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples its inputs from before the edge, independent of block order.
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + NB'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use stall, taken-branch flush and HALT drain control for the
// decode stage; the cases ALU forwarding from EX/MEM cannot resolve.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int N_REG            = 32,
    parameter int _NB_INDEX_REG    = $clog2(N_REG),
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int PIPE_DRAIN       = 3,
    parameter int NB_STALL_CNT     = 32
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic                     i_exe_memctl_read,
    input  logic [_NB_INDEX_REG-1:0] i_exe_regdest,
    input  logic [_NB_INDEX_REG-1:0] i_dec_indexRS,
    input  logic [_NB_INDEX_REG-1:0] i_dec_indexRT,
    input  logic                     i_dec_use_rs,
    input  logic                     i_dec_use_rt,
    input  logic                     i_dec_branch_taken,
    input  logic                     i_dec_halt,
    output logic                     o_pc_write,
    output logic                     o_ifid_write,
    output logic                     o_ifid_flush,
    output logic                     o_idex_bubble,
    output logic                     o_halted,
    output logic [NB_STALL_CNT-1:0]  o_stall_count
);

    localparam int NB_CNT = cnt_width(max2(LOAD_USE_BUBBLES, PIPE_DRAIN));
    localparam logic [NB_CNT-1:0] STALL_INIT = NB_CNT'(LOAD_USE_BUBBLES - 1);
    localparam logic [NB_CNT-1:0] DRAIN_INIT = NB_CNT'(PIPE_DRAIN - 1);
    localparam logic [NB_CNT-1:0] CNT_ONE    = NB_CNT'(1);

    hz_state_e         state, next_state;
    logic [NB_CNT-1:0] cnt, next_cnt;
    logic              hz;

    // Load in EX feeding a register that the instruction in decode reads.
    // R0 is hardwired to zero, so a load "into" it never blocks anything.
    assign hz = i_exe_memctl_read
              && (i_exe_regdest != '0)
              && ((i_dec_use_rs && (i_dec_indexRS == i_exe_regdest))
               || (i_dec_use_rt && (i_dec_indexRT == i_exe_regdest)));

    // Output decode and next-state selection; zero-latency control.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // case statement can leave one unassigned and infer a latch.
        o_pc_write    = 1'b1;
        o_ifid_write  = 1'b1;
        o_ifid_flush  = 1'b0;
        o_idex_bubble = 1'b0;
        next_state    = state;
        next_cnt      = cnt;

        if (!i_enable) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
        end else begin
            unique case (state)
                HZ_STATE_RUN: begin
                    if (hz) begin
                        // The hazard cycle is itself the first bubble; a
                        // pending branch is re-evaluated once decode resumes.
                        o_pc_write    = 1'b0;
                        o_ifid_write  = 1'b0;
                        o_idex_bubble = 1'b1;
                        if (LOAD_USE_BUBBLES > 1) begin
                            next_state = HZ_STATE_STALL;
                            next_cnt   = STALL_INIT;
                        end
                    end else if (i_dec_halt) begin
                        // HALT itself moves on to EX; fetch freezes behind it.
                        o_pc_write   = 1'b0;
                        o_ifid_write = 1'b0;
                        next_state   = HZ_STATE_DRAIN;
                        next_cnt     = DRAIN_INIT;
                    end else if (i_dec_branch_taken) begin
                        o_ifid_flush = 1'b1;
                    end
                end

                HZ_STATE_STALL: begin
                    // cnt holds the bubbles still owed, this one included,
                    // so the hazard totals exactly LOAD_USE_BUBBLES bubbles.
                    o_pc_write    = 1'b0;
                    o_ifid_write  = 1'b0;
                    o_idex_bubble = 1'b1;
                    if (cnt <= CNT_ONE) begin
                        next_state = HZ_STATE_RUN;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = cnt - CNT_ONE;
                    end
                end

                HZ_STATE_DRAIN: begin
                    // Counts PIPE_DRAIN-1 down to 0: PIPE_DRAIN bubble cycles
                    // while HALT retires through EX, MEM and WB.
                    o_pc_write    = 1'b0;
                    o_ifid_write  = 1'b0;
                    o_idex_bubble = 1'b1;
                    if (cnt == '0) begin
                        next_state = HZ_STATE_HALTED;
                    end else begin
                        next_cnt = cnt - CNT_ONE;
                    end
                end

                HZ_STATE_HALTED: begin
                    o_pc_write    = 1'b0;
                    o_ifid_write  = 1'b0;
                    o_idex_bubble = 1'b1;
                end
            endcase
        end
    end

    // State and down-counter; when disabled the next values equal the
    // current ones, so the whole controller freezes.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= HZ_STATE_RUN;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    assign o_halted = (state == HZ_STATE_HALTED);

    // Debug counter of bubble cycles; the bubble is already low when disabled.
    hazard_sat_counter #(
        .NB (NB_STALL_CNT)
    ) u_stall_cnt (
        .clock (i_clock),
        .reset (i_reset),
        .inc   (i_enable && o_idex_bubble),
        .count (o_stall_count)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: default instance plus a
// LOAD_USE_BUBBLES=2 instance with a 2-bit counter to reach saturation.
module tb_hazard_stall_unit;

    logic       clk;
    logic       rst;
    logic       en;
    logic       memrd;
    logic [4:0] regdest;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       branch;
    logic       halt;

    logic        pc_w, ifid_w, flush, bubble, halted;
    logic [31:0] cnt;
    logic        pc_w2, ifid_w2, flush2, bubble2, halted2;
    logic [1:0]  cnt2;

    logic [3:0] ctl, ctl2;
    assign ctl  = {pc_w, ifid_w, flush, bubble};
    assign ctl2 = {pc_w2, ifid_w2, flush2, bubble2};

    // {pc_write, ifid_write, ifid_flush, idex_bubble}
    localparam logic [3:0] C_RUN   = 4'b1100;
    localparam logic [3:0] C_BUB   = 4'b0001;
    localparam logic [3:0] C_FLUSH = 4'b1110;
    localparam logic [3:0] C_OFF   = 4'b0000;

    int checks   = 0;
    int failures = 0;

    hazard_stall_unit u_dut (
        .i_clock            (clk),
        .i_reset            (rst),
        .i_enable           (en),
        .i_exe_memctl_read  (memrd),
        .i_exe_regdest      (regdest),
        .i_dec_indexRS      (rs),
        .i_dec_indexRT      (rt),
        .i_dec_use_rs       (use_rs),
        .i_dec_use_rt       (use_rt),
        .i_dec_branch_taken (branch),
        .i_dec_halt         (halt),
        .o_pc_write         (pc_w),
        .o_ifid_write       (ifid_w),
        .o_ifid_flush       (flush),
        .o_idex_bubble      (bubble),
        .o_halted           (halted),
        .o_stall_count      (cnt)
    );

    hazard_stall_unit #(
        .LOAD_USE_BUBBLES (2),
        .NB_STALL_CNT     (2)
    ) u_dut2 (
        .i_clock            (clk),
        .i_reset            (rst),
        .i_enable           (en),
        .i_exe_memctl_read  (memrd),
        .i_exe_regdest      (regdest),
        .i_dec_indexRS      (rs),
        .i_dec_indexRT      (rt),
        .i_dec_use_rs       (use_rs),
        .i_dec_use_rt       (use_rt),
        .i_dec_branch_taken (branch),
        .i_dec_halt         (halt),
        .o_pc_write         (pc_w2),
        .o_ifid_write       (ifid_w2),
        .o_ifid_flush       (flush2),
        .o_idex_bubble      (bubble2),
        .o_halted           (halted2),
        .o_stall_count      (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks happen 2 units
    // later, well clear of either edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        en = 1'b1; memrd = 1'b0; regdest = '0; rs = '0; rt = '0;
        use_rs = 1'b0; use_rt = 1'b0; branch = 1'b0; halt = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] dst, input logic [4:0] s,
                            input logic [4:0] t, input logic urs, input logic urt);
        memrd = 1'b1; regdest = dst; rs = s; rt = t; use_rs = urs; use_rt = urt;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        checks++;
        if (ctl !== C_RUN) begin
            failures++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_RUN);
        end
        checks++;
        if (halted !== 1'b0) begin
            failures++; $display("FAIL reset_halted: got %b expected 0", halted);
        end
        checks++;
        if (cnt !== 32'd0) begin
            failures++; $display("FAIL reset_count: got %0d expected 0", cnt);
        end
        checks++;
        if (ctl2 !== C_RUN || cnt2 !== 2'd0) begin
            failures++; $display("FAIL reset_dut2: got ctl=%b cnt=%0d expected %b/0", ctl2, cnt2, C_RUN);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        load_use(5'd5, 5'd5, 5'd9, 1'b1, 1'b0);
        settle();
        checks++;
        if (ctl !== C_BUB) begin
            failures++; $display("FAIL load_use_rs_bubble: got %b expected %b", ctl, C_BUB);
        end
        step(); idle(); settle();
        checks++;
        if (ctl !== C_RUN || cnt !== 32'd1) begin
            failures++; $display("FAIL load_use_rs_after: got ctl=%b cnt=%0d expected %b/1", ctl, cnt, C_RUN);
        end
        // Match on RT
        load_use(5'd7, 5'd1, 5'd7, 1'b0, 1'b1);
        settle();
        checks++;
        if (ctl !== C_BUB) begin
            failures++; $display("FAIL load_use_rt_bubble: got %b expected %b", ctl, C_BUB);
        end
        step();
        // RS matches but is not read: no hazard
        load_use(5'd3, 5'd3, 5'd4, 1'b0, 1'b1);
        settle();
        checks++;
        if (ctl !== C_RUN) begin
            failures++; $display("FAIL load_use_unread_rs: got %b expected %b", ctl, C_RUN);
        end
        step();
        // Not a load: forwarding covers it
        load_use(5'd3, 5'd3, 5'd3, 1'b1, 1'b1);
        memrd = 1'b0;
        settle();
        checks++;
        if (ctl !== C_RUN) begin
            failures++; $display("FAIL load_use_not_load: got %b expected %b", ctl, C_RUN);
        end
        step(); idle(); settle();
        checks++;
        if (cnt !== 32'd2) begin
            failures++; $display("FAIL load_use_count: got %0d expected 2", cnt);
        end
    endtask

    task automatic test_r0();
        do_reset();
        load_use(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        settle();
        checks++;
        if (ctl !== C_RUN) begin
            failures++; $display("FAIL r0_no_stall: got %b expected %b", ctl, C_RUN);
        end
        step(); idle(); settle();
        checks++;
        if (cnt !== 32'd0) begin
            failures++; $display("FAIL r0_count: got %0d expected 0", cnt);
        end
    endtask

    task automatic test_branch();
        do_reset();
        branch = 1'b1;
        settle();
        checks++;
        if (ctl !== C_FLUSH) begin
            failures++; $display("FAIL branch_flush: got %b expected %b", ctl, C_FLUSH);
        end
        step(); idle(); settle();
        checks++;
        if (ctl !== C_RUN) begin
            failures++; $display("FAIL branch_one_cycle: got %b expected %b", ctl, C_RUN);
        end
        // Branch together with a load-use hazard: bubble first, flush next
        load_use(5'd8, 5'd8, 5'd0, 1'b1, 1'b0);
        branch = 1'b1;
        settle();
        checks++;
        if (ctl !== C_BUB) begin
            failures++; $display("FAIL branch_hz_bubble: got %b expected %b", ctl, C_BUB);
        end
        step();
        memrd = 1'b0;
        settle();
        checks++;
        if (ctl !== C_FLUSH) begin
            failures++; $display("FAIL branch_hz_flush_next: got %b expected %b", ctl, C_FLUSH);
        end
        step(); idle();
    endtask

    task automatic test_halt();
        do_reset();
        halt = 1'b1;
        settle();
        checks++;
        if (ctl !== C_OFF || halted !== 1'b0) begin
            failures++; $display("FAIL halt_issue: got ctl=%b halted=%b expected %b/0", ctl, halted, C_OFF);
        end
        step(); idle();
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (ctl !== C_BUB || halted !== 1'b0) begin
                failures++; $display("FAIL halt_drain%0d: got ctl=%b halted=%b expected %b/0", i, ctl, halted, C_BUB);
            end
            step();
        end
        settle();
        checks++;
        if (halted !== 1'b1 || cnt !== 32'd3) begin
            failures++; $display("FAIL halt_done: got halted=%b cnt=%0d expected 1/3", halted, cnt);
        end
        // Decode activity must not wake it; every halted cycle is a bubble
        for (int i = 0; i < 10; i++) begin
            load_use(5'd2, 5'd2, 5'd2, 1'b1, 1'b1);
            branch = (i % 2) == 0;
            settle();
            checks++;
            if (halted !== 1'b1 || ctl !== C_BUB || cnt !== 32'(3 + i)) begin
                failures++;
                $display("FAIL halt_hold%0d: got halted=%b ctl=%b cnt=%0d expected 1/%b/%0d", i, halted, ctl, cnt, C_BUB, 3 + i);
            end
            step();
        end
        idle();
    endtask

    task automatic test_enable_drain();
        do_reset();
        halt = 1'b1;
        step(); idle();
        settle();
        checks++;
        if (ctl !== C_BUB) begin
            failures++; $display("FAIL en_drain_first: got %b expected %b", ctl, C_BUB);
        end
        step();
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++;
            if (ctl !== C_OFF || cnt !== 32'd1 || halted !== 1'b0) begin
                failures++; $display("FAIL en_freeze%0d: got ctl=%b cnt=%0d halted=%b expected %b/1/0", i, ctl, cnt, halted, C_OFF);
            end
            step();
        end
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++;
            if (ctl !== C_BUB || halted !== 1'b0) begin
                failures++; $display("FAIL en_resume%0d: got ctl=%b halted=%b expected %b/0", i, ctl, halted, C_BUB);
            end
            step();
        end
        settle();
        checks++;
        if (halted !== 1'b1 || cnt !== 32'd3) begin
            failures++; $display("FAIL en_drain_done: got halted=%b cnt=%0d expected 1/3", halted, cnt);
        end
        // Halted flag is held while disabled
        en = 1'b0;
        step(); settle();
        checks++;
        if (halted !== 1'b1 || ctl !== C_OFF || cnt !== 32'd3) begin
            failures++; $display("FAIL en_halted_hold: got halted=%b ctl=%b cnt=%0d expected 1/%b/3", halted, ctl, cnt, C_OFF);
        end
        idle();
    endtask

    task automatic test_two_bubbles();
        do_reset();
        load_use(5'd6, 5'd0, 5'd6, 1'b0, 1'b1);
        settle();
        checks++;
        if (ctl2 !== C_BUB) begin
            failures++; $display("FAIL lub2_first: got %b expected %b", ctl2, C_BUB);
        end
        // Decode inputs are ignored during the stall
        step(); idle(); branch = 1'b1; halt = 1'b1;
        settle();
        checks++;
        if (ctl2 !== C_BUB) begin
            failures++; $display("FAIL lub2_second: got %b expected %b", ctl2, C_BUB);
        end
        step(); idle(); settle();
        checks++;
        if (ctl2 !== C_RUN || cnt2 !== 2'd2) begin
            failures++; $display("FAIL lub2_after: got ctl=%b cnt=%0d expected %b/2", ctl2, cnt2, C_RUN);
        end
        // Two more bubbles: 2-bit counter saturates at 3
        load_use(5'd6, 5'd6, 5'd0, 1'b1, 1'b0);
        step(); idle(); step(); settle();
        checks++;
        if (ctl2 !== C_RUN || cnt2 !== 2'd3) begin
            failures++; $display("FAIL lub2_saturate: got ctl=%b cnt=%0d expected %b/3", ctl2, cnt2, C_RUN);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        load_use(5'd4, 5'd4, 5'd0, 1'b1, 1'b0);
        step(); idle();
        rst = 1'b1;
        settle();
        checks++;
        if (ctl2 !== C_BUB) begin
            failures++; $display("FAIL rst_stall_in_stall: got %b expected %b", ctl2, C_BUB);
        end
        step();
        rst = 1'b0;
        settle();
        checks++;
        if (ctl2 !== C_RUN || cnt2 !== 2'd0 || halted2 !== 1'b0) begin
            failures++; $display("FAIL rst_stall_clean: got ctl=%b cnt=%0d halted=%b expected %b/0/0", ctl2, cnt2, halted2, C_RUN);
        end
        // Mid-drain reset on the default instance
        halt = 1'b1;
        step(); idle(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        checks++;
        if (ctl !== C_RUN || cnt !== 32'd0 || halted !== 1'b0) begin
            failures++; $display("FAIL rst_drain_clean: got ctl=%b cnt=%0d halted=%b expected %b/0/0", ctl, cnt, halted, C_RUN);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        test_reset();
        test_load_use();
        test_r0();
        test_branch();
        test_halt();
        test_enable_drain();
        test_two_bubbles();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
